alu_sub_serial: RTL and testbench

- Multi-cycle digit-serial subtractor: rd = rs1 - rs2 in two's complement, processing DIGIT bits per clock.
- Serves as the area-reduced inverse counterpart of the combinational alu_add in the ALU function set.
- Uses a start/busy/done handshake and a registered result.
- Also produces carry, zero, negative and signed-overflow flags for branch/compare use.

---
 rtl/alu_sub_serial.sv | 127 ++++++++++++
 tb/tb_alu_sub_serial.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sub_serial.sv
// alu_sub_serial: multi-cycle digit-serial subtractor, rd = rs1 - rs2 (two's complement).
// Processes DIGIT bits per clock over N = WIDTH/DIGIT RUN cycles as rs1 + ~rs2 + 1.
// WIDTH must be a multiple of DIGIT.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset, priority over everything
//   start  - request, accepted only in IDLE or DONE
//   rs1    - minuend, captured on the accepting edge
//   rs2    - subtrahend, captured on the accepting edge
//   busy   - high while the digit loop is running
//   done   - one-cycle pulse when rd and the flags become valid
//   rd     - registered difference, held until the next accepted start
//   carry  - final carry-out (1 = no unsigned borrow, rs1 >= rs2 unsigned)
//   zero   - rd == 0
//   neg    - rd[WIDTH-1]
//   ovf    - signed overflow of the subtraction
module alu_sub_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [CntW-1:0]  cnt_q;
  logic             cy_q;
  logic [WIDTH-1:0] rd_q;
  logic             carry_q, zero_q, neg_q, ovf_q;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   s;
  logic [WIDTH-1:0] res_next;
  logic             a_msb, b_msb;

  assign accept = start && (state_q == StIdle || state_q == StDone);
  assign last   = (state_q == StRun) && (cnt_q == CntW'(N - 1));

  // One digit of rs1 + ~rs2 + cy, one bit wider to keep the carry-out.
  assign s = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};

  // New digit enters at the top; on the last digit this is the complete difference.
  assign res_next = WIDTH'({s[DIGIT-1:0], r_q} >> DIGIT);

  // By the last digit the operands have shifted so their original sign bits sit at DIGIT-1.
  assign a_msb = a_q[DIGIT-1];
  assign b_msb = b_q[DIGIT-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      rd_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= rs1;
      b_q   <= rs2;
      cnt_q <= '0;
      cy_q  <= 1'b1;
    end else if (state_q == StRun) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      r_q   <= res_next;
      cy_q  <= s[DIGIT];
      cnt_q <= cnt_q + CntW'(1);
      if (last) begin
        rd_q    <= res_next;
        carry_q <= s[DIGIT];
        zero_q  <= (res_next == '0);
        neg_q   <= res_next[WIDTH-1];
        ovf_q   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
      end
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign rd    = rd_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_alu_sub_serial.sv
module tb_alu_sub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, busy, done, carry, zero, neg, ovf;
  logic [31:0] rs1, rs2, rd;
  logic        start4, busy4, done4, carry4, zero4, neg4, ovf4;
  logic [31:0] rs1_4, rs2_4, rd4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sub_serial dut (
    .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .rd(rd), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  alu_sub_serial #(.WIDTH(32), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .rs1(rs1_4), .rs2(rs2_4),
    .busy(busy4), .done(done4), .rd(rd4), .carry(carry4), .zero(zero4), .neg(neg4),
    .ovf(ovf4)
  );

  // Pulse start for one accepting edge; returns at the cycle after it, 1ns past the edge.
  task automatic go(input logic [31:0] x, input logic [31:0] y);
    rs1   = x;
    rs2   = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle k0 is the current one; returns at the negedge of the done cycle (lat = -1 on timeout).
  task automatic run_wait(input int k0, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = k0; k <= k0 + 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, carry, zero, neg, ovf} !== 6'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy/done/c/z/n/v=%b rd=%h, required 000000 and 0",
               {busy, done, carry, zero, neg, ovf}, rd);
    end
    checks++;
    if ({busy4, done4, carry4, zero4, neg4, ovf4} !== 6'b0 || rd4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_d4: busy/done/c/z/n/v=%b rd=%h, required 000000 and 0",
               {busy4, done4, carry4, zero4, neg4, ovf4}, rd4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    go(32'd1, 32'd1);
    run_wait(1, lat, bc);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL basic_latency: got %0d, required 33", lat);
    end
    checks++;
    if (bc !== 32 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy: busy cycles %0d busy_at_done %b, required 32 and 0", bc, busy);
    end
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL basic_rd: got %h, required 00000000", rd);
    end
    checks++;
    if ({carry, zero, neg, ovf} !== 4'b1100) begin
      failures++;
      $display("FAIL basic_flags: czno got %b, required 1100", {carry, zero, neg, ovf});
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL basic_hold: done %b rd %h, required 0 and 00000000", done, rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    go(32'd10, 32'hFFFFFFF6);
    run_wait(1, lat, bc);
    checks++;
    if (lat !== 33 || rd !== 32'd20 || {carry, zero, neg, ovf} !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_first: lat %0d rd %h czno %b, required 33 00000014 0000",
               lat, rd, {carry, zero, neg, ovf});
    end
    // Still in the DONE cycle: request the next operation with no bubble.
    go(32'hFFFFFFF6, 32'd10);
    run_wait(1, lat, bc);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL b2b_latency: got %0d, required 33", lat);
    end
    checks++;
    if (rd !== 32'hFFFFFFEC || {carry, zero, neg, ovf} !== 4'b1010) begin
      failures++;
      $display("FAIL b2b_second: rd %h czno %b, required ffffffec 1010", rd, {carry, zero, neg, ovf});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int lat, bc;
    go(32'h80000000, 32'd1);
    run_wait(1, lat, bc);
    checks++;
    if (lat !== 33 || rd !== 32'h7FFFFFFF || {carry, zero, neg, ovf} !== 4'b1001) begin
      failures++;
      $display("FAIL wrap_min_minus_1: lat %0d rd %h czno %b, required 33 7fffffff 1001",
               lat, rd, {carry, zero, neg, ovf});
    end
    @(posedge clk); #1;
    go(32'd0, 32'd1);
    run_wait(1, lat, bc);
    checks++;
    if (lat !== 33 || rd !== 32'hFFFFFFFF || {carry, zero, neg, ovf} !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_0_minus_1: lat %0d rd %h czno %b, required 33 ffffffff 0010",
               lat, rd, {carry, zero, neg, ovf});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    go(32'd1533353160, 32'd935318918);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    rs1   = 32'hDEADBEEF;
    rs2   = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    rs1   = 32'h0;
    rs2   = 32'hFFFFFFFF;
    run_wait(6, lat, bc);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL ignore_latency: got %0d, required 33", lat);
    end
    checks++;
    if (rd !== 32'd598034242 || {carry, zero, neg, ovf} !== 4'b1000) begin
      failures++;
      $display("FAIL ignore_result: rd %0d czno %b, required 598034242 1000",
               rd, {carry, zero, neg, ovf});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int lat, bc;
    bit saw;
    go(32'h12345678, 32'd1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, carry, zero, neg, ovf} !== 6'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL midrst_state: busy/done/c/z/n/v=%b rd=%h, required 000000 and 0",
               {busy, done, carry, zero, neg, ovf}, rd);
    end
    @(posedge clk); #1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_done: activity seen %b, required 0", saw);
    end
    go(32'd100, 32'd58);
    run_wait(1, lat, bc);
    checks++;
    if (lat !== 33 || rd !== 32'd42 || {carry, zero, neg, ovf} !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_fresh: lat %0d rd %0d czno %b, required 33 42 1000",
               lat, rd, {carry, zero, neg, ovf});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_digit4();
    logic [31:0] da [4];
    logic [31:0] db [4];
    logic [31:0] x, y, e;
    logic [3:0]  ef;
    int          lat;
    da = '{32'h0, 32'h80000000, 32'h5, 32'hFFFFFFFF};
    db = '{32'h1, 32'h1, 32'h5, 32'h7FFFFFFF};
    for (int i = 0; i < 1000; i++) begin
      if (i < 4) begin
        x = da[i];
        y = db[i];
      end else begin
        x = $urandom;
        y = $urandom;
      end
      e  = x - y;
      ef = {(x >= y), (e == 32'h0), e[31], (x[31] != y[31]) && (e[31] != x[31])};
      rs1_4  = x;
      rs2_4  = y;
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (done4) begin
          lat = k;
          break;
        end
        @(posedge clk); #1;
      end
      checks++;
      if (lat !== 9) begin
        failures++;
        $display("FAIL d4_latency[%0d]: got %0d, required 9", i, lat);
      end
      checks++;
      if (rd4 !== e) begin
        failures++;
        $display("FAIL d4_rd[%0d]: %h-%h got %h, required %h", i, x, y, rd4, e);
      end
      checks++;
      if ({carry4, zero4, neg4, ovf4} !== ef) begin
        failures++;
        $display("FAIL d4_flags[%0d]: %h-%h czno got %b, required %b",
                 i, x, y, {carry4, zero4, neg4, ovf4}, ef);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    rs1    = '0;
    rs2    = '0;
    start4 = 1'b0;
    rs1_4  = '0;
    rs2_4  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_ignore_start();
    test_mid_reset();
    test_digit4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
